mw_stage: RTL
=============

Name: mw_stage

Overview:
- Memory-write (MW) stage at the tail of the AG/MR/EX pipeline. It is the writer counterpart to the MR-stage memory read path.
- Latches EX results and issues memory write requests to the memory model (we/addr/data out, write_finished in).
- Performs register-file and flag writeback, stalls upstream while a write is outstanding, and counts retired instructions.

Parameters:
TIMEOUT, 64, max cycles to wait for write_finished before entering the error state (>=2)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock
r  in  1  reset: synchronous, active-high
ex_v  in  1  EX result valid
ex_we  in  1  instruction writes a data destination
ex_addr  in  32  memory destination address
ex_aluval  in  32  ALU result
ex_cc  in  32  current flags
ex_newcc  in  32  ALU-produced flags
ex_ccw  in  32  flag write mask
ex_modrm  in  8  modrm byte; mod=[7:6], rm=[2:0]
write_finished  in  1  memory write-done pulse
mw_stall  out  1  upstream must hold EX contents
mem_we  out  1  memory write request
mem_addr  out  32  write address
mem_wdata  out  32  write data
rf_we  out  1  register-file write pulse
rf_idx  out  3  register index (= rm)
rf_data  out  32  register write data
cc_we  out  1  flag write pulse
cc_out  out  32  merged flags
retire_cnt  out  CNT_W  retired-instruction count
mw_err  out  1  sticky write-timeout error

Behaviour:
- All outputs are registered except mw_stall.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- States:
  - IDLE: no write outstanding.
  - WRITE: memory write in flight.
  - ERR: write timed out.
- Capture condition: a posedge with ex_v=1 and mw_stall=0 latches all ex_* inputs into the stage.
- Classification of a captured instruction:
  - mem-write: ex_we=1 and mod!=2'b11.
  - reg-write: ex_we=1 and mod=2'b11.
  - no-data: ex_we=0.
- Flag merge: cc_out = (ex_cc & ~ex_ccw) | (ex_newcc & ex_ccw), using latched values. cc_we=1 only if ex_ccw != 0.
- Retire: one cycle of cc_we (if mask nonzero) together with retire_cnt+1. retire_cnt wraps at 2^CNT_W to 0.
- reg-write or no-data instruction:
  - Retires on the cycle after capture.
  - reg-write also pulses rf_we=1 in that same cycle, with rf_idx=rm and rf_data=ex_aluval.
  - State stays IDLE; latency 1 cycle.
- mem-write instruction:
  - On the capture edge: state<=WRITE, mem_we<=1, mem_addr<=ex_addr, mem_wdata<=ex_aluval, timeout counter<=0.
  - In WRITE: mem_we, mem_addr and mem_wdata are held constant; counter increments each cycle.
- mw_stall = (state==WRITE & ~write_finished) | (state==ERR).
  - Combinational, so a new instruction may be captured on the same edge a write completes (back-to-back).
- Write completion: in WRITE with write_finished=1 at a posedge:
  - mem_we<=0 and the instruction retires (cc_we and count registered on that edge).
  - state<=IDLE, or directly back to WRITE if a new mem-write is captured on the same edge.
- Simultaneous retire and capture: a non-mem instruction captured on the completion edge retires one cycle later. Retire pulses never merge; each instruction produces its own count increment.
- write_finished while not in WRITE: ignored.
- Timeout: in WRITE, if the counter reaches TIMEOUT-1 without write_finished:
  - state<=ERR, mem_we<=0, mw_err<=1.
  - No retire for the failed instruction.
- ERR: stall held and all pulses 0. Only r exits ERR.
- Reset mid-WRITE: next cycle mem_we=0, state IDLE, mw_err=0, retire_cnt=0; the pending write is abandoned.
- No captures while r=1.

Test Plan:
- Reg-write: ex_v=1, ex_we=1, modrm=8'hC3, aluval=32'h1234, ccw=32'h1, newcc=32'h1, cc=0 -> next cycle rf_we=1, rf_idx=3, rf_data=32'h1234, cc_we=1, cc_out=32'h1, retire_cnt=1, mw_stall never 1.
- Mem-write: modrm=8'h80, addr=32'h0DEF0002, aluval=32'hABCD, write_finished after 3 cycles -> mem_we=1 with addr/data stable for 3 cycles, mw_stall=1 for those cycles, mem_we=0 and retire_cnt=1 after the completing edge.
- Back-to-back: second mem-write presented while the first waits; write_finished pulses -> second captured on the same edge, mem_addr switches to the second address without a mem_we gap, retire_cnt 1 then 2.
- Timeout with TIMEOUT=4 and write_finished held 0 -> after 4 cycles in WRITE: mw_err=1, mem_we=0, mw_stall=1 persistent, retire_cnt unchanged. Assert r -> all outputs 0.
- Reset mid-WRITE: r pulsed during the second WRITE cycle -> next cycle mem_we=0, mw_stall=0, retire_cnt=0. A later stray write_finished is ignored.
- Counter wrap with CNT_W=2: 5 consecutive no-data instructions (ccw=0) -> retire_cnt sequence 1,2,3,0,1 and cc_we never asserted.

Source files
------------

// File: rtl/mw_if.sv
// EX-to-MW result bus plus the MW memory-write and writeback outputs.
// Signal names match the stage's external port list.
interface mw_if #(
  parameter int CNT_W = 16
);
  logic             ex_v;
  logic             ex_we;
  logic [31:0]      ex_addr;
  logic [31:0]      ex_aluval;
  logic [31:0]      ex_cc;
  logic [31:0]      ex_newcc;
  logic [31:0]      ex_ccw;
  logic [7:0]       ex_modrm;
  logic             write_finished;
  logic             mw_stall;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             rf_we;
  logic [2:0]       rf_idx;
  logic [31:0]      rf_data;
  logic             cc_we;
  logic [31:0]      cc_out;
  logic [CNT_W-1:0] retire_cnt;
  logic             mw_err;

  // Handshake: an EX result is taken on any posedge where ex_v=1 and
  // mw_stall=0; while mw_stall=1 upstream holds its ex_* values unchanged.
  modport slave (
    input  ex_v, ex_we, ex_addr, ex_aluval, ex_cc, ex_newcc, ex_ccw, ex_modrm,
           write_finished,
    output mw_stall, mem_we, mem_addr, mem_wdata, rf_we, rf_idx, rf_data,
           cc_we, cc_out, retire_cnt, mw_err
  );

  modport master (
    output ex_v, ex_we, ex_addr, ex_aluval, ex_cc, ex_newcc, ex_ccw, ex_modrm,
           write_finished,
    input  mw_stall, mem_we, mem_addr, mem_wdata, rf_we, rf_idx, rf_data,
           cc_we, cc_out, retire_cnt, mw_err
  );
endinterface

// File: rtl/mw_stage.sv
// Memory-write stage: issues data writes, does register/flag writeback,
// stalls upstream during outstanding writes and counts retirements.
module mw_stage #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic r,
  mw_if.slave  bus,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_ERR = 2'd2} state_t;
  localparam int TW = $clog2(TIMEOUT);

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic             rf_we_q, rf_we_d;
  logic [2:0]       rf_idx_q, rf_idx_d;
  logic [31:0]      rf_data_q, rf_data_d;
  logic             cc_we_q, cc_we_d;
  logic [31:0]      cc_out_q, cc_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  // Flag result of the in-flight memory write, retired on completion.
  logic             pend_ccwe_q, pend_ccwe_d;
  logic [31:0]      pend_cc_q, pend_cc_d;
  // One-deep slot for a non-mem instruction whose retire edge is taken.
  logic             dfr_v_q, dfr_v_d, dfr_rfwe_q, dfr_rfwe_d, dfr_ccwe_q, dfr_ccwe_d;
  logic [2:0]       dfr_idx_q, dfr_idx_d;
  logic [31:0]      dfr_data_q, dfr_data_d, dfr_cc_q, dfr_cc_d;

  logic        stall, capture, is_mem, is_reg, new_ccwe, retire_mem;
  logic [31:0] merged;
  logic        unused_modrm;

  assign stall      = ((state_q == ST_WRITE) && !bus.write_finished) || (state_q == ST_ERR);
  assign capture    = bus.ex_v && !stall && !r;
  assign is_mem     = bus.ex_we && (bus.ex_modrm[7:6] != 2'b11);
  assign is_reg     = bus.ex_we && (bus.ex_modrm[7:6] == 2'b11);
  assign merged     = (bus.ex_cc & ~bus.ex_ccw) | (bus.ex_newcc & bus.ex_ccw);
  assign new_ccwe   = |bus.ex_ccw;
  assign retire_mem = (state_q == ST_WRITE) && bus.write_finished;
  assign unused_modrm = ^bus.ex_modrm[5:3];

  always_comb begin
    state_d = state_q;         tmo_d = tmo_q;
    mem_we_d = mem_we_q;       mem_addr_d = mem_addr_q;   mem_wdata_d = mem_wdata_q;
    rf_we_d = 1'b0;            rf_idx_d = rf_idx_q;       rf_data_d = rf_data_q;
    cc_we_d = 1'b0;            cc_out_d = cc_out_q;
    cnt_d = cnt_q;             err_d = err_q;
    pend_ccwe_d = pend_ccwe_q; pend_cc_d = pend_cc_q;
    dfr_v_d = dfr_v_q;         dfr_rfwe_d = dfr_rfwe_q;   dfr_ccwe_d = dfr_ccwe_q;
    dfr_idx_d = dfr_idx_q;     dfr_data_d = dfr_data_q;   dfr_cc_d = dfr_cc_q;

    case (state_q)
      ST_WRITE: begin
        if (bus.write_finished) begin
          mem_we_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          mem_we_d = 1'b0;
          state_d  = ST_ERR;
          err_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: ;
    endcase

    // At most one retirement per edge: completing write, then deferred slot.
    if (retire_mem) begin
      cc_we_d  = pend_ccwe_q;
      cc_out_d = pend_cc_q;
      cnt_d    = cnt_q + 1'b1;
    end else if (dfr_v_q) begin
      rf_we_d  = dfr_rfwe_q;
      if (dfr_rfwe_q) begin
        rf_idx_d  = dfr_idx_q;
        rf_data_d = dfr_data_q;
      end
      cc_we_d  = dfr_ccwe_q;
      cc_out_d = dfr_cc_q;
      cnt_d    = cnt_q + 1'b1;
      dfr_v_d  = 1'b0;
    end

    if (capture) begin
      if (is_mem) begin
        state_d     = ST_WRITE;
        tmo_d       = '0;
        mem_we_d    = 1'b1;
        mem_addr_d  = bus.ex_addr;
        mem_wdata_d = bus.ex_aluval;
        pend_ccwe_d = new_ccwe;
        pend_cc_d   = merged;
      end else if (retire_mem || dfr_v_q) begin
        dfr_v_d    = 1'b1;
        dfr_rfwe_d = is_reg;
        dfr_idx_d  = bus.ex_modrm[2:0];
        dfr_data_d = bus.ex_aluval;
        dfr_ccwe_d = new_ccwe;
        dfr_cc_d   = merged;
      end else begin
        rf_we_d = is_reg;
        if (is_reg) begin
          rf_idx_d  = bus.ex_modrm[2:0];
          rf_data_d = bus.ex_aluval;
        end
        cc_we_d  = new_ccwe;
        cc_out_d = merged;
        cnt_d    = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= ST_IDLE;  tmo_q <= '0;
      mem_we_q <= 1'b0;    mem_addr_q <= '0;  mem_wdata_q <= '0;
      rf_we_q <= 1'b0;     rf_idx_q <= '0;    rf_data_q <= '0;
      cc_we_q <= 1'b0;     cc_out_q <= '0;    cnt_q <= '0;    err_q <= 1'b0;
      pend_ccwe_q <= 1'b0; pend_cc_q <= '0;
      dfr_v_q <= 1'b0;     dfr_rfwe_q <= 1'b0; dfr_ccwe_q <= 1'b0;
      dfr_idx_q <= '0;     dfr_data_q <= '0;   dfr_cc_q <= '0;
    end else begin
      state_q <= state_d;  tmo_q <= tmo_d;
      mem_we_q <= mem_we_d; mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
      rf_we_q <= rf_we_d;  rf_idx_q <= rf_idx_d;  rf_data_q <= rf_data_d;
      cc_we_q <= cc_we_d;  cc_out_q <= cc_out_d;  cnt_q <= cnt_d;  err_q <= err_d;
      pend_ccwe_q <= pend_ccwe_d; pend_cc_q <= pend_cc_d;
      dfr_v_q <= dfr_v_d;  dfr_rfwe_q <= dfr_rfwe_d; dfr_ccwe_q <= dfr_ccwe_d;
      dfr_idx_q <= dfr_idx_d; dfr_data_q <= dfr_data_d; dfr_cc_q <= dfr_cc_d;
    end
  end

  assign bus.mw_stall   = stall;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_idx     = rf_idx_q;
  assign bus.rf_data    = rf_data_q;
  assign bus.cc_we      = cc_we_q;
  assign bus.cc_out     = cc_out_q;
  assign bus.retire_cnt = cnt_q;
  assign bus.mw_err     = err_q;
  assign state_o        = state_q;
endmodule
